// File: rtl/package_settings.sv
// package_settings: system-wide data widths shared by the ADC-side blocks.
package package_settings;
   localparam int SIZE_ADC_DATA = 12;
endpackage

// File: rtl/pulse_gen_pkg.sv
// pulse_gen_parameters: fixed-point format, state type, LFSR seed and output saturation helpers for pulse_gen.
package pulse_gen_parameters;
   import package_settings::*;
   localparam int FRAC_BITS = 8;
   localparam int ACC_W = SIZE_ADC_DATA + FRAC_BITS + 1;
   localparam int EXT_W = ACC_W + 2;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(2**FRAC_BITS);
   localparam logic signed [EXT_W-1:0] OUT_HI = EXT_W'(2**(SIZE_ADC_DATA-1) - 1);
   localparam logic signed [EXT_W-1:0] OUT_LO = EXT_W'(-(2**(SIZE_ADC_DATA-1)));
   typedef enum logic [1:0] {IDLE, RISE, DECAY} pulse_state_t;
   function automatic logic signed [SIZE_ADC_DATA-1:0] sat_adc(input logic signed [EXT_W-1:0] v);
      return v > OUT_HI ? OUT_HI[SIZE_ADC_DATA-1:0] : v < OUT_LO ? OUT_LO[SIZE_ADC_DATA-1:0] : v[SIZE_ADC_DATA-1:0];
   endfunction
   function automatic logic clamps(input logic signed [EXT_W-1:0] v);
      return v > OUT_HI || v < OUT_LO;
   endfunction
endpackage

// File: rtl/pulse_gen_lfsr.sv
// pulse_gen_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11) used as pulse_gen output noise.
// Ports: clk; reset (sync, active-high, reloads the seed); en advances one step; out is the register.
module pulse_gen_lfsr
   import pulse_gen_parameters::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [15:0] out
);
   always_ff @(posedge clk) begin
      if (reset) out <= LFSR_SEED;
      else if (en) out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
   end
endmodule

// File: rtl/pulse_gen.sv
// pulse_gen: synthetic detector pulse source, linear ramp to amplitude then exponential decay, signed ADC samples.
// Ports: clk; reset (sync, active-high); sample_en ADC-rate strobe; start_valid/start_ready pulse request
//   handshake carrying signed amplitude; output_data/out_valid sample stream (one sample latency);
//   busy while a pulse is rising or decaying; sat_flag sticky clamp indicator.
// Optional: define PULSE_GEN_NOISE_EN to add LFSR noise in -4..+3 ahead of output saturation.
module pulse_gen
   import package_settings::*;
   import pulse_gen_parameters::*;
#(
   parameter int RISE_LOG2 = 2,
   parameter int DECAY_SHIFT = 5,
   parameter int signed BASELINE = 0
)
(
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            sample_en,
   input  logic                            start_valid,
   output logic                            start_ready,
   input  logic signed [SIZE_ADC_DATA-1:0] amplitude,
   output logic signed [SIZE_ADC_DATA-1:0] output_data,
   output logic                            out_valid,
   output logic                            busy,
   output logic                            sat_flag
);
   localparam int RISE_W = RISE_LOG2 + 1;
   localparam logic [RISE_W-1:0] RISE_N = RISE_W'(2**RISE_LOG2);
   localparam logic signed [EXT_W-1:0] BASE_EXT = EXT_W'(BASELINE);
   pulse_state_t r_state;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] r_step;
   logic [RISE_W-1:0] r_rise_cnt;
   logic signed [ACC_W-1:0] w_amp_ext;
   logic signed [ACC_W-1:0] w_step_next;
   logic signed [ACC_W:0] w_sum;
   logic w_sum_ovf;
   logic signed [ACC_W-1:0] w_sum_sat;
   logic signed [ACC_W-1:0] w_decay;
   logic w_decay_done;
   logic w_accept;
   logic signed [EXT_W-1:0] w_noise;
   logic signed [EXT_W-1:0] w_out_raw;
   assign start_ready = (r_state != RISE);
   assign busy = (r_state != IDLE);
   assign w_accept = start_valid && start_ready;
   assign w_amp_ext = ACC_W'(amplitude);
   assign w_step_next = (w_amp_ext <<< FRAC_BITS) >>> RISE_LOG2;
   // one guard bit detects ramp overflow; clamp toward the sign of the true sum
   assign w_sum = {r_acc[ACC_W-1], r_acc} + {r_step[ACC_W-1], r_step};
   assign w_sum_ovf = w_sum[ACC_W] != w_sum[ACC_W-1];
   assign w_sum_sat = w_sum_ovf ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];
   assign w_decay = r_acc >>> DECAY_SHIFT;
   // sub-LSB residue ends the pulse; also stops negative pulses creeping toward -1 forever
   assign w_decay_done = (w_decay == '0) || (r_acc < ACC_ONE && r_acc > -ACC_ONE);
`ifdef PULSE_GEN_NOISE_EN
   logic [15:0] w_lfsr;
   pulse_gen_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (sample_en),
      .out   (w_lfsr)
   );
   assign w_noise = EXT_W'(signed'({1'b0, w_lfsr[2:0]})) - EXT_W'(4);
`else
   assign w_noise = '0;
`endif
   assign w_out_raw = BASE_EXT + EXT_W'(r_acc >>> FRAC_BITS) + w_noise;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_acc <= '0;
         r_step <= '0;
         r_rise_cnt <= '0;
         output_data <= sat_adc(BASE_EXT);
         out_valid <= 1'b0;
         sat_flag <= 1'b0;
      end else begin
         out_valid <= sample_en;
         if (sample_en) begin
            output_data <= sat_adc(w_out_raw);
            if (clamps(w_out_raw) || (r_state == RISE && w_sum_ovf)) sat_flag <= 1'b1;
            if (r_state == RISE) begin
               r_acc <= w_sum_sat;
               r_rise_cnt <= r_rise_cnt - RISE_W'(1);
               if (r_rise_cnt == RISE_W'(1)) r_state <= DECAY;
            end else if (r_state == DECAY) begin
               r_acc <= w_decay_done ? '0 : r_acc - w_decay;
               if (w_decay_done) r_state <= IDLE;
            end
         end
         // accept overrides the state update above; acc keeps any residual for pile-up
         if (w_accept) begin
            r_step <= w_step_next;
            r_rise_cnt <= RISE_N;
            r_state <= RISE;
         end
      end
   end
endmodule

// File: tb/tb_pulse_gen.sv
// tb_pulse_gen: self-checking bench for pulse_gen against an arithmetic pulse model.
module tb_pulse_gen;
   import package_settings::*;
   localparam int FB = 8;
   localparam int RL = 2;
   localparam int DS = 5;
   localparam int BASE = 0;
   localparam int OMAX = 2**(SIZE_ADC_DATA-1) - 1;
   localparam int OMIN = -(2**(SIZE_ADC_DATA-1));
   localparam longint AMAX = (longint'(1) << (SIZE_ADC_DATA + FB)) - 1;
   localparam longint AMIN = -(longint'(1) << (SIZE_ADC_DATA + FB));
   logic clk = 1'b0;
   logic reset, sample_en, start_valid;
   logic start_ready, out_valid, busy, sat_flag;
   logic signed [SIZE_ADC_DATA-1:0] amplitude, output_data;
   pulse_gen #(.RISE_LOG2(RL), .DECAY_SHIFT(DS), .BASELINE(BASE)) dut (
      .clk         (clk),
      .reset       (reset),
      .sample_en   (sample_en),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .amplitude   (amplitude),
      .output_data (output_data),
      .out_valid   (out_valid),
      .busy        (busy),
      .sat_flag    (sat_flag)
   );
   always #5 clk = ~clk;
   longint m_acc, m_step;
   int m_ramp, m_out, m_lfsr;
   bit m_active, m_valid, m_sat;
   int n_vec = 0;
   int n_bad = 0;
   typedef struct {bit sv; int amp; int out; bit busy; bit rdy;} vec_t;
   vec_t tbl[9];
   function automatic longint fdiv(longint a, longint b);
      longint q;
      q = a / b;
      if (a % b != 0 && a < 0) q -= 1;
      return q;
   endfunction
   task automatic chk(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask
   // model: a pulse is "ramp samples left" plus an active flag over a wide integer accumulator
   task automatic model(input bit r, input bit en, input bit sv, input int amp);
      bit accept;
      longint v;
      int noise;
      if (r) begin
         m_acc = 0; m_ramp = 0; m_active = 0; m_valid = 0; m_sat = 0;
         m_out = BASE > OMAX ? OMAX : BASE < OMIN ? OMIN : BASE;
         m_lfsr = 'hACE1;
      end else begin
         accept = sv && m_ramp == 0;
         m_valid = en;
         if (en) begin
            noise = 0;
`ifdef PULSE_GEN_NOISE_EN
            noise = (m_lfsr & 7) - 4;
            m_lfsr = ((m_lfsr << 1) & 'hFFFF) | ($countones(m_lfsr & 'hB400) & 1);
`endif
            v = BASE + fdiv(m_acc, 2**FB) + noise;
            if (v > OMAX) begin m_out = OMAX; m_sat = 1; end
            else if (v < OMIN) begin m_out = OMIN; m_sat = 1; end
            else m_out = int'(v);
            if (m_ramp > 0) begin
               m_acc += m_step;
               if (m_acc > AMAX) begin m_acc = AMAX; m_sat = 1; end
               if (m_acc < AMIN) begin m_acc = AMIN; m_sat = 1; end
               m_ramp--;
            end else if (m_active) begin
               if ((m_acc > -(2**FB) && m_acc < 2**FB) || fdiv(m_acc, 2**DS) == 0) begin
                  m_acc = 0;
                  m_active = 0;
               end else m_acc -= fdiv(m_acc, 2**DS);
            end
         end
         if (accept) begin
            m_step = fdiv(longint'(amp) * (2**FB), 2**RL);
            m_ramp = 2**RL;
            m_active = 1;
         end
      end
   endtask
   task automatic tick(input bit r, input bit en, input bit sv, input int amp);
      reset = r; sample_en = en; start_valid = sv; amplitude = SIZE_ADC_DATA'(amp);
      @(posedge clk);
      #1;
      model(r, en, sv, amp);
      chk("out", output_data, m_out);
      chk("valid", out_valid, m_valid);
      chk("busy", busy, m_active);
      chk("ready", start_ready, m_ramp == 0);
      chk("sat", sat_flag, m_sat);
   endtask
   task automatic wait_idle(input int max);
      for (int k = 0; k < max && busy; k++) tick(0, 1, 0, 0);
      chk("idle_timeout", busy, 0);
   endtask
   initial begin
      int p;
      tbl[0] = '{1, 400,   0, 1, 0};
      tbl[1] = '{1,   0,   0, 1, 0};
      tbl[2] = '{1,   0, 100, 1, 0};
      tbl[3] = '{1,   0, 200, 1, 0};
      tbl[4] = '{1,   0, 300, 1, 1};
      tbl[5] = '{0,   0, 400, 1, 1};
      tbl[6] = '{0,   0, 387, 1, 1};
      tbl[7] = '{0,   0, 375, 1, 1};
      tbl[8] = '{0,   0, 363, 1, 1};
      tick(1, 0, 0, 0);
      chk("rst_out", output_data, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", start_ready, 1);
      chk("rst_sat", sat_flag, 0);
      for (int i = 0; i < 9; i++) begin
         tick(0, 1, tbl[i].sv, tbl[i].amp);
         chk("tbl_out", output_data, tbl[i].out);
         chk("tbl_busy", busy, tbl[i].busy);
         chk("tbl_ready", start_ready, tbl[i].rdy);
      end
      for (int k = 0; k < 50 && m_out > 352; k++) begin
         p = m_out;
         tick(0, 1, 0, 0);
         chk("mono", int'(output_data <= p), 1);
      end
      tick(0, 1, 1, 400);
      tick(0, 1, 0, 0);
      p = m_out;
      for (int k = 0; k < 4; k++) begin
         tick(0, 1, 0, 0);
         p += 100;
         chk("pileup_ramp", output_data, p);
      end
      wait_idle(1000);
      tick(0, 1, 0, 0);
      chk("single_end", output_data, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 1, -256);
      tick(0, 1, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         tick(0, 1, 0, 0);
         chk("neg_ramp", output_data, -64 * k);
      end
      wait_idle(1000);
      tick(0, 1, 0, 0);
      chk("neg_end", output_data, 0);
      tick(1, 0, 0, 0);
      tick(0, 1, 1, 2000);
      for (int k = 0; k < 4; k++) tick(0, 1, 0, 0);
      tick(0, 1, 1, 2000);
      for (int k = 0; k < 5; k++) tick(0, 1, 0, 0);
      chk("sat_out", output_data, 2047);
      chk("sat_flag", sat_flag, 1);
      wait_idle(2000);
      chk("sat_sticky", sat_flag, 1);
      tick(0, 1, 1, 400);
      tick(0, 1, 0, 0);
      tick(1, 1, 0, 0);
      chk("midrst_out", output_data, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", start_ready, 1);
      chk("midrst_sat", sat_flag, 0);
      tick(0, 1, 1, 400);
      tick(0, 1, 0, 0);
      tick(0, 1, 0, 0);
      chk("after_rst1", output_data, 100);
      tick(0, 1, 0, 0);
      chk("after_rst2", output_data, 200);
      tick(1, 0, 0, 0);
      for (int c = 0; c < 400; c++) tick(0, c % 4 == 0, c == 1 || c == 150, c == 1 ? 300 : -500);
      for (int c = 0; c < 3000; c++)
         tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
              int'($urandom_range(0, 4095)) - 2048);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
